// File: rtl/div_pkg.sv
// Shared constants and FSM encoding for the sequential divider.
// Optional signed mode is enabled by defining DIV_SIGNED_EN.
package div_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int GRP       = 4;

  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int CNT_W = cnt_width(WIDTH_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla_sub_16bit.sv
// Carry-lookahead subtractor: diff = a + ~b + 1, borrow = ~carry-out.
// Built from 4-bit group generate/propagate terms.
module cla_sub_16bit
  import div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int NG = (WIDTH + GRP - 1) / GRP;
  localparam int PW = NG * GRP;

  always_comb begin : cla
    logic [PW-1:0] aa;
    logic [PW-1:0] bn;
    logic [PW-1:0] g;
    logic [PW-1:0] p;
    logic [PW-1:0] c;
    logic [PW-1:0] s;
    logic [NG:0]   gc;
    logic          gg;
    logic          gp;
    // pad bits propagate so the group chain is not cut short
    aa = '0;
    bn = '1;
    aa[WIDTH-1:0] = a;
    bn[WIDTH-1:0] = ~b;
    g  = aa & bn;
    p  = aa ^ bn;
    c  = '0;
    gc = '0;
    gc[0] = 1'b1;
    for (int k = 0; k < NG; k++) begin
      gg = 1'b0;
      gp = 1'b1;
      for (int i = 0; i < GRP; i++) begin
        gg = g[k*GRP+i] | (p[k*GRP+i] & gg);
        gp = gp & p[k*GRP+i];
      end
      gc[k+1] = gg | (gp & gc[k]);
      c[k*GRP] = gc[k];
      for (int i = 0; i < GRP - 1; i++) begin
        c[k*GRP+i+1] = g[k*GRP+i] |
                       (p[k*GRP+i] & c[k*GRP+i]);
      end
    end
    s      = p ^ c;
    diff   = s[WIDTH-1:0];
    borrow = ~gc[NG];
  end

endmodule

// File: rtl/seq_divider_16bit.sv
// Sequential restoring divider, one quotient bit per cycle.
// Define DIV_SIGNED_EN to add the signed_op port and signed mode.
module seq_divider_16bit
  import div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef DIV_SIGNED_EN
  input  logic             signed_op,
`endif
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_t state, state_nx;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, q, dvsr;
  logic             neg_q, neg_r;
  logic             accept, zero_dvsr, last;
  logic [WIDTH-1:0] rem_sh, diff, rem_nx, q_nx;
  logic             borrow, no_borrow;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;

  assign accept    = start && (state != RUN);
  assign zero_dvsr = (divisor == '0);
  assign last      = (cnt == CW'(WIDTH - 1));

`ifdef DIV_SIGNED_EN
  assign a_neg = signed_op & dividend[WIDTH-1];
  assign b_neg = signed_op & divisor[WIDTH-1];
`else
  assign a_neg = 1'b0;
  assign b_neg = 1'b0;
`endif

  assign a_abs = a_neg ? (~dividend + WIDTH'(1))
                       : dividend;
  assign b_abs = b_neg ? (~divisor + WIDTH'(1))
                       : divisor;

  assign rem_sh = {rem[WIDTH-2:0], q[WIDTH-1]};

  cla_sub_16bit #(
    .WIDTH (WIDTH)
  ) u_sub (
    .a      (rem_sh),
    .b      (dvsr),
    .diff   (diff),
    .borrow (borrow)
  );

  // a bit shifted out of rem means the trial value already exceeds dvsr
  assign no_borrow = ~borrow | rem[WIDTH-1];
  assign rem_nx    = no_borrow ? diff : rem_sh;
  assign q_nx      = {q[WIDTH-2:0], no_borrow};

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: begin
        if (start) state_nx = zero_dvsr ? DONE : RUN;
        else       state_nx = IDLE;
      end
      RUN: begin
        if (last) state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      rem         <= '0;
      q           <= '0;
      dvsr        <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      cnt   <= '0;
      rem   <= '0;
      q     <= a_abs;
      dvsr  <= b_abs;
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
      if (zero_dvsr) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end
    end else if (state == RUN) begin
      cnt <= cnt + CW'(1);
      rem <= rem_nx;
      q   <= q_nx;
      if (last) begin
        quotient    <= neg_q ? -q_nx : q_nx;
        remainder   <= neg_r ? -rem_nx : rem_nx;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider_16bit.sv
// Self-checking bench for seq_divider_16bit (directed vectors).
// Signed vectors run only when DIV_SIGNED_EN is defined.
module tb_seq_divider_16bit;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         signed_op;
  logic [W-1:0] dividend, divisor;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seq_divider_16bit #(
    .WIDTH (W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
`ifdef DIV_SIGNED_EN
    .signed_op   (signed_op),
`endif
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic void ref_div(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sg,
    output logic [W-1:0] qo,
    output logic [W-1:0] ro,
    output logic         zo);
    int sa, sb;
    if (b == '0) begin
      qo = '1; ro = a; zo = 1'b1;
    end else begin
      zo = 1'b0;
      if (sg) begin
        sa = $signed(a);
        sb = $signed(b);
        qo = W'(sa / sb);
        ro = W'(sa % sb);
      end else begin
        qo = a / b;
        ro = a % b;
      end
    end
  endfunction

  // model: edges left until done (-1 = nothing pending)
  int           m_ph;
  logic [W-1:0] p_q, p_r, s_q, s_r;
  logic         p_z, s_z;

  initial begin : model
    int old;
    m_ph = -1;
    s_q = '0; s_r = '0; s_z = 1'b0;
    p_q = '0; p_r = '0; p_z = 1'b0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_ph = -1;
        s_q = '0; s_r = '0; s_z = 1'b0;
      end else begin
        old = m_ph;
        if (m_ph >= 0) m_ph--;
        if (start && old <= 0) begin
          ref_div(dividend, divisor, signed_op,
                  p_q, p_r, p_z);
          m_ph = (divisor == '0) ? 0 : W;
        end
        if (m_ph == 0) begin
          s_q = p_q; s_r = p_r; s_z = p_z;
        end
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      check("busy", 32'(busy), 32'(m_ph > 0));
      check("done", 32'(done), 32'(m_ph == 0));
      if (m_ph <= 0) begin
        check("quotient", 32'(quotient), 32'(s_q));
        check("remainder", 32'(remainder), 32'(s_r));
        check("div_by_zero", 32'(div_by_zero), 32'(s_z));
      end
    end
  end

  task automatic go(input logic [W-1:0] dd,
                    input logic [W-1:0] dv,
                    input logic         sg);
    dividend  = dd;
    divisor   = dv;
    signed_op = sg;
    start     = 1'b1;
  endtask

  task automatic wait_done(input int expn, input string nm);
    int  n;
    bit  seen;
    seen = 1'b0;
    n    = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (done) begin
        seen = 1'b1;
        n    = i;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s latency: no done in 40 cycles", nm);
    end else begin
      check({nm, " latency"}, 32'(n), 32'(expn));
    end
  endtask

  task automatic chk_res(input string nm,
                         input logic [W-1:0] eq,
                         input logic [W-1:0] er,
                         input logic         ez);
    check({nm, " q"}, 32'(quotient), 32'(eq));
    check({nm, " r"}, 32'(remainder), 32'(er));
    check({nm, " dbz"}, 32'(div_by_zero), 32'(ez));
  endtask

  task automatic chk_zero(input string nm);
    check({nm, " busy"}, 32'(busy), 32'd0);
    check({nm, " done"}, 32'(done), 32'd0);
    chk_res(nm, '0, '0, 1'b0);
  endtask

  initial begin : stim
    rst_n     = 1'b0;
    start     = 1'b0;
    signed_op = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    go(16'd100, 16'd7, 1'b0);
    wait_done(17, "100/7");
    chk_res("100/7", 16'd14, 16'd2, 1'b0);
    @(negedge clk);

    go(16'hFFFF, 16'h0001, 1'b0);
    wait_done(17, "ffff/1");
    chk_res("ffff/1", 16'hFFFF, 16'h0000, 1'b0);
    go(16'h0005, 16'h0009, 1'b0);
    wait_done(17, "5/9 b2b");
    chk_res("5/9 b2b", 16'h0000, 16'h0005, 1'b0);
    repeat (3) @(negedge clk);
    chk_res("hold", 16'h0000, 16'h0005, 1'b0);

    go(16'h1234, 16'h0000, 1'b0);
    wait_done(1, "1234/0");
    chk_res("1234/0", 16'hFFFF, 16'h1234, 1'b1);
    @(negedge clk);

    go(16'd50, 16'd5, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    go(16'd9, 16'd3, 1'b0);
    wait_done(13, "50/5 ign");
    chk_res("50/5 ign", 16'd10, 16'd0, 1'b0);
    @(negedge clk);

    go(16'd1000, 16'd3, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("midrst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    go(16'd20, 16'd6, 1'b0);
    wait_done(17, "20/6");
    chk_res("20/6", 16'd3, 16'd2, 1'b0);
    @(negedge clk);

    go(16'h8000, 16'hFFFF, 1'b0);
    wait_done(17, "u8000/ffff");
    chk_res("u8000/ffff", 16'h0000, 16'h8000, 1'b0);
    @(negedge clk);

`ifdef DIV_SIGNED_EN
    go(16'hFFF9, 16'h0002, 1'b1);
    wait_done(17, "s-7/2");
    chk_res("s-7/2", 16'hFFFD, 16'hFFFF, 1'b0);
    @(negedge clk);
    go(16'h8000, 16'hFFFF, 1'b1);
    wait_done(17, "s8000/ffff");
    chk_res("s8000/ffff", 16'h8000, 16'h0000, 1'b0);
    @(negedge clk);
    go(16'd7, 16'hFFFE, 1'b1);
    wait_done(17, "s7/-2");
    chk_res("s7/-2", 16'hFFFD, 16'h0001, 1'b0);
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
